regfile_wb_ctrl: RTL and testbench

Write-port controller for the 32x32 general-purpose register file. It zero-fills every register after reset, then shares the file's single write port between two requesters. The requesters are the pipeline writeback stage and a long-latency unit (multiply/divide or load-miss return), with starvation protection for the latter. It sits between the WB stage and the register file's RDaddr/RDdata/RegWrite inputs, and replaces the direct WB-to-register-file connection.

---
 rtl/regfile_ctrl_pkg.sv | 22 ++
 rtl/rf_init_sweep.sv | 57 +++++
 rtl/regfile_wb_ctrl.sv | 93 +++++++++
 tb/tb_regfile_wb_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_ctrl_pkg
// Brief    : Shared types and defaults for the register-file write-port
//            controller (FSM state encoding, file depth, parameter defaults).
// Revision : 1.0 - initial release
// ============================================================================
package regfile_ctrl_pkg;

  // Controller phases: zero-fill sweep, then normal arbitration.
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int NUM_REGS       = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_ADDR_W     = 5;
  localparam int DEF_STARVE_MAX = 4;

endpackage : regfile_ctrl_pkg
`default_nettype wire

// File: rtl/rf_init_sweep.sv
`default_nettype none
// ============================================================================
// Module   : rf_init_sweep
// Brief    : Post-reset zero-fill sequencer. Walks every register address
//            once, then raises a sticky done flag that moves the controller
//            into its run phase.
// Revision : 1.0 - initial release
// ============================================================================
module rf_init_sweep
  import regfile_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  output logic              sweep_we_o,
  output logic [ADDR_W-1:0] sweep_addr_o,
  output logic              done_o
);

  // One extra counter bit: its MSB marks "every address has been issued".
  logic [ADDR_W:0] r_cnt;
  state_t          r_state;
  state_t          w_state_nxt;

  // State register; reset always restarts the sweep.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= ST_INIT;
    else          r_state <= w_state_nxt;
  end

  // Sweep address counter, advancing once per cycle until it passes the top.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                                r_cnt <= '0;
    else if (r_state == ST_INIT && !r_cnt[ADDR_W]) r_cnt <= r_cnt + 1'b1;
  end

  // Next state and sweep write request; RUN is entered once the last
  // address has been handed to the output register.
  always_comb begin
    w_state_nxt = r_state;
    sweep_we_o  = 1'b0;
    case (r_state)
      ST_INIT: begin
        sweep_we_o = !r_cnt[ADDR_W];
        if (r_cnt[ADDR_W]) w_state_nxt = ST_RUN;
      end
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  assign sweep_addr_o = r_cnt[ADDR_W-1:0];
  assign done_o       = (r_state == ST_RUN);

endmodule : rf_init_sweep
`default_nettype wire

// File: rtl/regfile_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_ctrl
// Brief    : Register-file write-port controller. Zero-fills the file after
//            reset, then arbitrates the single write port between the WB
//            stage (priority) and a long-latency unit with starvation guard.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              wb_valid_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic              wb_ready_o,
  input  logic              lu_valid_i,
  input  logic [ADDR_W-1:0] lu_addr_i,
  input  logic [DATA_W-1:0] lu_data_i,
  output logic              lu_ready_o,
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] rf_addr_o,
  output logic [DATA_W-1:0] rf_data_o,
  output logic              init_done_o
);

  localparam int c_CNT_W = $clog2(STARVE_MAX + 1);

  logic                w_run;
  logic                w_sweep_we;
  logic [ADDR_W-1:0]   w_sweep_addr;
  logic [c_CNT_W-1:0]  r_starve_cnt;
  logic                w_lu_starved;
  logic                w_wb_hs;
  logic                w_lu_hs;

  rf_init_sweep #(
    .ADDR_W (ADDR_W)
  ) u_sweep (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .sweep_we_o   (w_sweep_we),
    .sweep_addr_o (w_sweep_addr),
    .done_o       (w_run)
  );

  assign init_done_o  = w_run;
  assign w_lu_starved = (r_starve_cnt == c_CNT_W'(STARVE_MAX));

  // WB normally wins; a starved LU request takes the port for one cycle.
  assign wb_ready_o = w_run && !(lu_valid_i && w_lu_starved);
  assign lu_ready_o = w_run && (w_lu_starved || !wb_valid_i);
  assign w_wb_hs    = wb_valid_i && wb_ready_o;
  assign w_lu_hs    = lu_valid_i && lu_ready_o;

  // Count consecutive refused LU cycles, saturating at the starvation limit.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                              r_starve_cnt <= '0;
    else if (!w_run || w_lu_hs || !lu_valid_i) r_starve_cnt <= '0;
    else if (!w_lu_starved)                    r_starve_cnt <= r_starve_cnt + 1'b1;
  end

  // Output register: sweep writes during INIT, granted request during RUN.
  // Writes to r0 complete the handshake but never assert the write enable.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rf_we_o   <= 1'b0;
      rf_addr_o <= '0;
      rf_data_o <= '0;
    end else if (!w_run) begin
      rf_we_o   <= w_sweep_we;
      rf_addr_o <= w_sweep_addr;
      rf_data_o <= '0;
    end else if (w_wb_hs) begin
      rf_we_o   <= (wb_addr_i != '0);
      rf_addr_o <= wb_addr_i;
      rf_data_o <= wb_data_i;
    end else if (w_lu_hs) begin
      rf_we_o   <= (lu_addr_i != '0);
      rf_addr_o <= lu_addr_i;
      rf_data_o <= lu_data_i;
    end else begin
      rf_we_o   <= 1'b0;
    end
  end

endmodule : regfile_wb_ctrl
`default_nettype wire

// File: tb/tb_regfile_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_ctrl
// Brief    : Scoreboard bench for regfile_wb_ctrl with a register-file model
//            that captures writes on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid, lu_valid;
  logic [4:0]  wb_addr, lu_addr;
  logic [31:0] wb_data, lu_data;
  logic        wb_ready, lu_ready;
  logic        rf_we, init_done;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] mem[32];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  regfile_wb_ctrl #(
    .DATA_W     (32),
    .ADDR_W     (5),
    .STARVE_MAX (4)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .wb_valid_i  (wb_valid),
    .wb_addr_i   (wb_addr),
    .wb_data_i   (wb_data),
    .wb_ready_o  (wb_ready),
    .lu_valid_i  (lu_valid),
    .lu_addr_i   (lu_addr),
    .lu_data_i   (lu_data),
    .lu_ready_o  (lu_ready),
    .rf_we_o     (rf_we),
    .rf_addr_o   (rf_addr),
    .rf_data_o   (rf_data),
    .init_done_o (init_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [4:0] a, input logic [31:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    exp_q.push_back(w);
  endtask

  // Monitor: register-file model plus scoreboard pop on every write pulse.
  task automatic monitor_loop();
    wr_t w;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (!init_done) chk("ready_in_init", {30'd0, wb_ready, lu_ready}, 32'd0);
        if (rf_we) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: actual addr=%0d data=%h required no write", rf_addr, rf_data);
          end else begin
            w = exp_q.pop_front();
            chk("wr_addr", {27'd0, rf_addr}, {27'd0, w.a});
            chk("wr_data", rf_data, w.d);
          end
          mem[rf_addr] = rf_data;
        end
      end
    end
  endtask

  // One request cycle, starting and ending 1 time unit after a rising edge.
  task automatic step(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                      input logic lv, input logic [4:0] la, input logic [31:0] ld,
                      input logic ew, input logic el, output logic gw, output logic gl);
    wb_valid = wv; wb_addr = wa; wb_data = wd;
    lu_valid = lv; lu_addr = la; lu_data = ld;
    @(negedge clk);
    chk("wb_ready", {31'd0, wb_ready}, {31'd0, ew});
    chk("lu_ready", {31'd0, lu_ready}, {31'd0, el});
    gw = wv && wb_ready;
    gl = lv && lu_ready;
    if (gw && wa != 5'd0) push_exp(wa, wd);
    if (gl && la != 5'd0) push_exp(la, ld);
    @(posedge clk);
    #1;
  endtask

  // Release reset (called at a falling edge) and follow the zero-fill sweep.
  task automatic do_sweep();
    for (int i = 0; i < 32; i++) push_exp(5'(i), 32'd0);
    rst_n    = 1'b1;
    wb_valid = 1'b1; wb_addr = 5'd7;  wb_data = 32'h1111_1111;
    lu_valid = 1'b1; lu_addr = 5'd8;  lu_data = 32'h2222_2222;
    repeat (31) @(posedge clk);
    #1;
    wb_valid = 1'b0;
    lu_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("init_done_c32", {31'd0, init_done}, 32'd0);
    @(posedge clk);
    #1;
    chk("init_done_c33", {31'd0, init_done}, 32'd1);
    chk("sweep_all_seen", exp_q.size(), 32'd0);
    for (int i = 0; i < 32; i++) chk("readback_zero", mem[i], 32'd0);
  endtask

  initial begin
    logic gw, gl;
    logic [4:0] wa, la;
    rst_n = 1'b0;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    lu_valid = 1'b0; lu_addr = '0; lu_data = '0;
    for (int i = 0; i < 32; i++) mem[i] = 32'hBAD0_0000 | 32'(i);
    fork
      monitor_loop();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we",   {31'd0, rf_we}, 32'd0);
    chk("rst_addr", {27'd0, rf_addr}, 32'd0);
    chk("rst_data", rf_data, 32'd0);
    chk("rst_rdy",  {30'd0, wb_ready, lu_ready}, 32'd0);
    chk("rst_done", {31'd0, init_done}, 32'd0);

    // Test 1: zero-fill sweep
    @(negedge clk);
    do_sweep();

    // Test 2: single WB write to r5
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, gw, gl);
    chk("t2_we",   {31'd0, rf_we}, 32'd1);
    chk("t2_addr", {27'd0, rf_addr}, 32'd5);
    chk("t2_data", rf_data, 32'hDEADBEEF);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, gw, gl);
    chk("t2_r5", mem[5], 32'hDEADBEEF);

    // Test 3: both held valid, WB wins four cycles then LU wins one
    wa = 5'd10;
    la = 5'd20;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, wa, 32'h1000_0000 + 32'(wa), 1'b1, la, 32'h2000_0000 + 32'(la),
           (i % 5) != 4, (i % 5) == 4, gw, gl);
      if (gw) wa = wa + 5'd1;
      if (gl) la = la + 5'd1;
    end

    // Test 4: LU write to r0 handshakes but never writes
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h12345678, 1'b1, 1'b1, gw, gl);
    chk("t4_we", {31'd0, rf_we}, 32'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, gw, gl);
    chk("t4_r0", mem[0], 32'd0);

    // Test 5: back-to-back LU writes r1..r4
    for (int r = 1; r <= 4; r++) begin
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'(r), 32'hC0DE_0000 + 32'(r), 1'b1, 1'b1, gw, gl);
      chk("t5_we", {31'd0, rf_we}, 32'd1);
    end
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, gw, gl);
    for (int r = 1; r <= 4; r++) chk("t5_readback", mem[r], 32'hC0DE_0000 + 32'(r));

    // Test 6: asynchronous reset while a write is on the port
    step(1'b1, 5'd9, 32'hA5A5A5A5, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, gw, gl);
    wb_valid = 1'b0;
    chk("t6_pre_we", {31'd0, rf_we}, 32'd1);
    exp_q.delete();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_we",   {31'd0, rf_we}, 32'd0);
    chk("t6_addr", {27'd0, rf_addr}, 32'd0);
    chk("t6_data", rf_data, 32'd0);
    chk("t6_done", {31'd0, init_done}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    do_sweep();

    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, gw, gl);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, gw, gl);
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_regfile_wb_ctrl
`default_nettype wire
